// File: rtl/nrzi_tx.sv
// NRZI serial transmitter: frames each parallel word as a start marker plus LSB-first
// data bits, with optional bit stuffing after long runs of logical 1s.
module nrzi_tx #(
    parameter int DATA_W    = 8,
    parameter bit STUFF_EN  = 1'b1,
    parameter int STUFF_LEN = 6
) (
    input  logic              clk,
    input  logic              r,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              tx_bit,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int RUN_W = $clog2(STUFF_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STUFF_LEN);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, STUFF} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] shift, shift_nx;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx, bit_inc;
    logic [RUN_W-1:0]  run_cnt, run_nx, run_inc;
    logic              tx_nx, tx_bit_nx, ready_nx, done_nx;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            run_cnt   <= '0;
            tx        <= 1'b0;
            tx_bit    <= 1'b0;
            din_ready <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            shift     <= shift_nx;
            bit_cnt   <= bit_cnt_nx;
            run_cnt   <= run_nx;
            tx        <= tx_nx;
            tx_bit    <= tx_bit_nx;
            din_ready <= ready_nx;
            done      <= done_nx;
        end
    end

    // Run counter saturates so long runs with stuffing disabled cannot wrap.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_cnt_nx = bit_cnt;
        run_nx     = run_cnt;
        tx_nx      = tx;
        tx_bit_nx  = 1'b0;
        ready_nx   = din_ready;
        done_nx    = 1'b0;
        run_inc    = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        bit_inc    = bit_cnt + 1'b1;

        case (state)
            IDLE: begin
                ready_nx = 1'b1;
                if (din_valid && din_ready) begin
                    shift_nx = din;
                    ready_nx = 1'b0;
                    state_nx = SYNC;
                end
            end
            SYNC: begin
                tx_bit_nx  = 1'b1;
                tx_nx      = ~tx;
                run_nx     = RUN_W'(1);
                bit_cnt_nx = '0;
                state_nx   = DATA;
            end
            DATA: begin
                tx_bit_nx  = shift[0];
                tx_nx      = tx ^ shift[0];
                shift_nx   = shift >> 1;
                bit_cnt_nx = bit_inc;
                run_nx     = shift[0] ? run_inc : '0;
                if (STUFF_EN && (run_nx == RUN_MAX)) begin
                    state_nx = STUFF;
                end else if (bit_inc == BIT_LAST) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    ready_nx = 1'b1;
                end
            end
            STUFF: begin
                run_nx = '0;
                if (bit_cnt == BIT_LAST) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    ready_nx = 1'b1;
                end else begin
                    state_nx = DATA;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_nrzi_tx.sv
// Directed bench for nrzi_tx: hand-computed line streams, a receive-side transition
// detector on tx, plus a stuffing model for random words.
module tb_nrzi_tx;

    logic       clk = 1'b0;
    logic       r;
    logic [7:0] din;
    logic       validReq;
    logic       sel;
    logic       dinValid1, dinValid2;
    logic       ready1, tx1, txBit1, busy1, done1;
    logic       ready2, tx2, txBit2, busy2, done2;
    logic       obsReady, obsTx, obsTxBit, obsBusy, obsDone;
    logic       expLevel, prevTx;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign dinValid1 = validReq & ~sel;
    assign dinValid2 = validReq & sel;
    assign obsReady  = sel ? ready2 : ready1;
    assign obsTx     = sel ? tx2    : tx1;
    assign obsTxBit  = sel ? txBit2 : txBit1;
    assign obsBusy   = sel ? busy2  : busy1;
    assign obsDone   = sel ? done2  : done1;

    nrzi_tx #(.DATA_W(8), .STUFF_EN(1'b1), .STUFF_LEN(6)) dut (
        .clk(clk), .r(r), .din(din), .din_valid(dinValid1), .din_ready(ready1),
        .tx(tx1), .tx_bit(txBit1), .busy(busy1), .done(done1)
    );

    nrzi_tx #(.DATA_W(8), .STUFF_EN(1'b0), .STUFF_LEN(6)) dutNoStuff (
        .clk(clk), .r(r), .din(din), .din_valid(dinValid2), .din_ready(ready2),
        .tx(tx2), .tx_bit(txBit2), .busy(busy2), .done(done2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word, input bit holdValid);
        int waitCycles = 0;
        while (!obsReady && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!obsReady) checkOutput("ready_timeout", obsReady, 1);
        din      = word;
        validReq = 1'b1;
        @(posedge clk); #1;
        if (!holdValid) validReq = 1'b0;
        checkOutput("accept_busy", obsBusy, 1);
        checkOutput("accept_ready", obsReady, 0);
    endtask

    task automatic checkFrame(input string tag, input logic [15:0] stream, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            expLevel = expLevel ^ stream[i];
            checkOutput({tag, "_tx"}, obsTx, expLevel);
            checkOutput({tag, "_bit"}, obsTxBit, stream[i]);
            checkOutput({tag, "_det"}, obsTx ^ prevTx, obsTxBit);
            checkOutput({tag, "_done"}, obsDone, (i == nbits - 1));
            if (i < nbits - 1) checkOutput({tag, "_busy"}, obsBusy, 1);
            prevTx = obsTx;
        end
        checkOutput({tag, "_end_busy"}, obsBusy, 0);
        checkOutput({tag, "_end_ready"}, obsReady, 1);
    endtask

    // Reference framing for random words: start 1, LSB-first data, stuff 0 after six 1s.
    task automatic modelStream(input logic [7:0] w, output logic [15:0] s, output int n);
        int run;
        s   = 16'h0001;
        n   = 1;
        run = 1;
        for (int i = 0; i < 8; i++) begin
            s[n] = w[i];
            n++;
            run = w[i] ? run + 1 : 0;
            if (run == 6) begin
                s[n] = 1'b0;
                n++;
                run = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] s;
        int          n;
        logic [7:0]  w;

        r        = 1'b0;
        din      = 8'hFF;
        validReq = 1'b1;
        sel      = 1'b0;
        expLevel = 1'b0;
        prevTx   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx", obsTx, 0);
        checkOutput("rst_ready", obsReady, 0);
        checkOutput("rst_busy", obsBusy, 0);
        checkOutput("rst_done", obsDone, 0);
        checkOutput("rst_bit", obsTxBit, 0);
        r = 1'b1;
        @(posedge clk); #1;
        checkOutput("first_ready", obsReady, 1);
        checkOutput("first_busy", obsBusy, 0);
        validReq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_tx", obsTx, 0);
        checkOutput("idle_busy", obsBusy, 0);
        checkOutput("idle_bit", obsTxBit, 0);

        sel = 1'b1;
        expLevel = 1'b0;
        prevTx = 1'b0;
        applyStimulus(8'hFC, 1'b0);
        checkFrame("fc_nostuff", 16'h01F9, 9);

        sel = 1'b0;
        expLevel = 1'b0;
        prevTx = 1'b0;
        applyStimulus(8'hA5, 1'b0);
        checkFrame("a5", 16'h014B, 9);
        applyStimulus(8'hFF, 1'b0);
        checkFrame("ff", 16'h03BF, 10);
        applyStimulus(8'hFC, 1'b0);
        checkFrame("fc", 16'h01F9, 10);

        applyStimulus(8'hA5, 1'b1);
        din = 8'h3C;
        checkFrame("b2b_a", 16'h014B, 9);
        @(posedge clk); #1;
        checkOutput("b2b_accept_busy", obsBusy, 1);
        checkOutput("b2b_accept_ready", obsReady, 0);
        checkOutput("b2b_hold_tx", obsTx, expLevel);
        checkOutput("b2b_hold_bit", obsTxBit, 0);
        checkOutput("b2b_hold_done", obsDone, 0);
        validReq = 1'b0;
        checkFrame("b2b_b", 16'h0079, 9);

        applyStimulus(8'hA5, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        r = 1'b0;
        #1;
        checkOutput("abort_tx", obsTx, 0);
        checkOutput("abort_busy", obsBusy, 0);
        checkOutput("abort_ready", obsReady, 0);
        checkOutput("abort_done", obsDone, 0);
        checkOutput("abort_bit", obsTxBit, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_hold_done", obsDone, 0);
        r = 1'b1;
        expLevel = 1'b0;
        prevTx = 1'b0;
        applyStimulus(8'h01, 1'b0);
        checkFrame("one", 16'h0003, 9);

        for (int k = 0; k < 8; k++) begin
            w = 8'($urandom_range(0, 255));
            modelStream(w, s, n);
            applyStimulus(w, 1'b0);
            checkFrame("rand", s, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
